delay_line_prog: RTL
====================

// Module: delay_line_prog
// PURPOSE
//   Multi-channel programmable sample delay line with per-channel delay select.
//   Circular-buffer storage replaces a register chain, so depth scales to 2^AW.
//   Processes a strobed (en) sample stream and mutes each channel until its history is valid.
//   Sits in the ADC/DAC datapath to align channels and trigger taps, e.g. 2 x 14-bit at 125 MHz.
// PARAMETERS
//   DW   14  sample width per channel, bits
//   NCH  2   number of channels; all channels share one write pointer
//   AW   6   address width; buffer depth 2^AW; max delay 2^AW-1 samples
// PORTS
//   clk       in   1        clock, all logic rising-edge
//   rst_n     in   1        asynchronous, active-low reset
//   clr       in   1        synchronous flush of history (pointer and fill count)
//   en        in   1        sample strobe; din is valid when en=1
//   din       in   NCH*DW   input samples; channel c at [c*DW +: DW]
//   sel       in   NCH*AW   delay in samples per channel; channel c at [c*AW +: AW]
//   dout      out  NCH*DW   delayed samples, registered
//   dout_vld  out  1        strobe; dout updated this cycle, mirrors en one clock late
//   dout_ok   out  NCH      channel c has full history for its current sel
// BEHAVIOUR
//   - Reset (rst_n=0, async): wr_ptr=0, fill=0, dout=0, dout_vld=0, dout_ok=0.
//     Buffer contents are not cleared; muting hides stale data.
//   - Delay definition: at the k-th accepted strobe, dout[c] = din[c] from strobe k-sel[c].
//     This is counted in en strobes, not clocks.
//   - Latency: dout/dout_vld register the result one clk after the en cycle.
//     sel=0 is a 1-clk registered pass-through of din (bypass; the buffer is not read).
//   - On en=1, clr=0, per channel:
//     - rd_addr = (wr_ptr - sel[c]) mod 2^AW.
//     - The read completes before the same-cycle write.
//     - mem[wr_ptr] <= din, then wr_ptr <= wr_ptr+1 (wraps 2^AW-1 -> 0).
//   - fill counts accepted strobes since reset/clr and saturates at 2^AW-1.
//   - Mute rule, evaluated with fill before the increment:
//     - ok_c = (sel[c] <= fill).
//     - dout[c] <= ok_c ? data : 0.
//     - dout_ok[c] <= ok_c.
//   - en=0: dout and dout_ok hold their values; dout_vld <= 0; wr_ptr and fill are unchanged.
//   - sel change: takes effect at the next strobe with no extra latency.
//     - Increase beyond fill: channel is muted (0, ok=0) until fill catches up.
//     - Decrease: channel is valid immediately.
//     - Glitch samples from the change are accepted; there is no crossfade.
//   - clr=1: wr_ptr<=0, fill<=0, dout<=0, dout_ok<=0, dout_vld<=0.
//     clr has priority over a simultaneous en; that sample is dropped and not written.
//   - Wrap-around: with sel=2^AW-1, the read address equals wr_ptr+1.
//     That is the oldest entry, never the entry being written.
//   - Arithmetic: pointers are unsigned AW bits, mod 2^AW.
//     Samples are passed bit-exact with no sign processing.
//   - Reset asserted mid-stream: outputs go to 0 immediately (async).
//     After release, the history restarts from fill=0.
// TESTING
//   - Reset, en=1 every clk, din=ramp 1,2,3..., sel=0
//     -> dout = din one clk late, dout_vld=1, dout_ok=1.
//   - sel[0]=5, sel[1]=63, continuous ramp from 1
//     -> ch0 is 0 with ok=0 for 5 strobes, then 1,2,3...
//     -> ch1 is muted for 63 strobes, then 1..., proving wrap-around.
//   - en toggling 1-0-1-0, sel=3, ramp
//     -> delay counted in strobes; dout holds during gaps; dout_vld pulses one clk after each en.
//   - Streaming at sel=4, switch to sel=10 after 6 strobes
//     -> channel muted (0, ok=0) until fill reaches 10, then din[k-10].
//   - Switch back to sel=2 -> valid at the next strobe.
//   - clr=1 coincident with en and din=0x1234
//     -> sample dropped; outputs 0; fill restarts; sel=1 gives ok=1 only from the 2nd strobe after clr.
//   - rst_n pulled low mid-stream for one cycle
//     -> dout=0, dout_vld=0 asynchronously; behaviour after release matches a fresh reset.

Source files
------------

// File: rtl/delay_line_prog.sv
// Multi-channel programmable sample delay line with a circular buffer per channel.
// All channels share one write pointer and fill count. A channel is muted until enough history exists for its delay.
module delay_line_prog #(
    parameter int DW  = 14,
    parameter int NCH = 2,
    parameter int AW  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [NCH*DW-1:0] din,
    input  logic [NCH*AW-1:0] sel,
    output logic [NCH*DW-1:0] dout,
    output logic              dout_vld,
    output logic [NCH-1:0]    dout_ok
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] FILL_MAX = '1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     fill_q, fill_d;
    logic [NCH*DW-1:0] dout_q, dout_d;
    logic [NCH-1:0]    ok_q, ok_d;
    logic              vld_q, vld_d;
    logic [DW-1:0]     mem_q [NCH][DEPTH];

    always_comb begin
        logic [AW-1:0] sel_c;
        logic [AW-1:0] rd_addr;
        logic          ok_c;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        dout_d   = dout_q;
        ok_d     = ok_q;
        vld_d    = 1'b0;
        sel_c    = '0;
        rd_addr  = '0;
        ok_c     = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            dout_d   = '0;
            ok_d     = '0;
        end else if (en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
            vld_d    = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                sel_c   = sel[c*AW +: AW];
                rd_addr = wr_ptr_q - sel_c;
                // fill is taken before this strobe's increment
                ok_c    = (sel_c <= fill_q);
                ok_d[c] = ok_c;
                if (!ok_c)
                    dout_d[c*DW +: DW] = '0;
                else if (sel_c == '0)
                    dout_d[c*DW +: DW] = din[c*DW +: DW];
                else
                    dout_d[c*DW +: DW] = mem_q[c][rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            dout_q   <= '0;
            ok_q     <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            dout_q   <= dout_d;
            ok_q     <= ok_d;
            vld_q    <= vld_d;
        end
    end

    // Storage is never reset; stale entries are hidden by the mute rule.
    always_ff @(posedge clk) begin
        if (en && !clr) begin
            for (int c = 0; c < NCH; c++)
                mem_q[c][wr_ptr_q] <= din[c*DW +: DW];
        end
    end

    assign dout     = dout_q;
    assign dout_ok  = ok_q;
    assign dout_vld = vld_q;

endmodule
